blackbox_prober: RTL and testbench

Sequential test harness that drives the three inputs (`j`, `v`, `f`) of a 3-input combinational black box and captures its output `l`. It applies all 8 input combinations in order, one vector at a time. Each vector is held for a programmable settle time before `l` is sampled. The result is an 8-bit truth table plus the minterm count, and a comparison against an expected table. It sits on the lab bench between the stimulus controller and a black-box instance, and is the reader side of the black box's input/output interface.

---
 rtl/blackbox_prober.sv | 137 +++++++++++++
 tb/tb_blackbox_prober.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/blackbox_prober.sv
// blackbox_prober: sweeps all eight {j,v,f} input vectors of a 3-input
// combinational black box. Each vector is held for SETTLE cycles, and l_in
// is captured on the last cycle of that window. The result is a truth table,
// its population count, and a compare against an expected table.
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high
//   start        begin a sweep (sampled in IDLE/DONE only)
//   expected     reference truth table, bit i = expected l for {j,v,f} = i
//   l_in         black-box output under test
//   j, v, f      black-box drive, {j,v,f} = current vector index
//   busy         sweep in progress
//   done         results valid
//   truth_table  captured table, bit i = l_in sampled for index i
//                ("table" is a reserved word, so the port is named truth_table)
//   ones         population count of truth_table (0..8)
//   match        truth_table == expected, valid while done
module blackbox_prober #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       l_in,
    output logic       j,
    output logic       v,
    output logic       f,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic [3:0] ones,
    output logic       match
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 3;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tbl_q, tbl_d;
    logic [3:0]       ones_q, ones_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             match_q, match_d;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tbl_q   <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        ones_d  = ones_q;
        busy_d  = busy_q;
        done_d  = done_q;
        match_d = match_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    cnt_d   = RELOAD;
                    tbl_d   = '0;
                    ones_d  = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    match_d = 1'b0;
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Capture edge for the current vector
                    tbl_d[idx_q] = l_in;
                    ones_d       = ones_q + 4'(l_in);
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = RELOAD;
                    end else begin
                        state_d = S_DONE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        // Compare uses the table including this final capture
                        match_d = (tbl_d == expected);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign {j, v, f}   = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tbl_q;
    assign ones        = ones_q;
    assign match       = match_q;

endmodule

// File: tb/tb_blackbox_prober.sv
// Testbench for blackbox_prober: one instance with SETTLE=1 and one with
// SETTLE=3. Each instance drives a modelled black box that is just a lookup
// into an 8-bit truth table.
module tb_blackbox_prober;

    logic             clk;
    logic [1:0]       rst_w;
    logic [1:0]       start_w;
    logic [1:0][7:0]  exp_w;
    logic [1:0][7:0]  box_r;
    logic [1:0]       lin_w;
    logic [1:0]       j_w, v_w, f_w, busy_w, done_w, match_w;
    logic [1:0][7:0]  tbl_w;
    logic [1:0][3:0]  ones_w;

    int total = 0;
    int bad   = 0;

    blackbox_prober #(.SETTLE(1)) dut1 (
        .clock(clk), .reset(rst_w[0]), .start(start_w[0]), .expected(exp_w[0]),
        .l_in(lin_w[0]), .j(j_w[0]), .v(v_w[0]), .f(f_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .truth_table(tbl_w[0]), .ones(ones_w[0]), .match(match_w[0])
    );

    blackbox_prober #(.SETTLE(3)) dut3 (
        .clock(clk), .reset(rst_w[1]), .start(start_w[1]), .expected(exp_w[1]),
        .l_in(lin_w[1]), .j(j_w[1]), .v(v_w[1]), .f(f_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .truth_table(tbl_w[1]), .ones(ones_w[1]), .match(match_w[1])
    );

    // Black boxes: output is the box table entry addressed by {j,v,f}
    assign lin_w[0] = box_r[0][{j_w[0], v_w[0], f_w[0]}];
    assign lin_w[1] = box_r[1][{j_w[1], v_w[1], f_w[1]}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;      // 0: SETTLE=1 instance, 1: SETTLE=3 instance
        logic [7:0] box;
        logic [7:0] expv;
        logic [7:0] et;
        logic [3:0] eo;
        logic       em;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_busy"}, 32'(busy_w[d]), 32'd0);
        chk({tag, "_done"}, 32'(done_w[d]), 32'd0);
        chk({tag, "_match"}, 32'(match_w[d]), 32'd0);
        chk({tag, "_table"}, 32'(tbl_w[d]), 32'd0);
        chk({tag, "_ones"}, 32'(ones_w[d]), 32'd0);
        chk({tag, "_jvf"}, 32'({j_w[d], v_w[d], f_w[d]}), 32'd0);
    endtask

    // One full sweep. Vector index after edge n is n / SETTLE; results appear
    // after edge 8*SETTLE. restart_at >= 0 re-pulses start during RUN.
    task automatic sweep(input int d, input logic [7:0] box, input logic [7:0] expv,
                         input logic [7:0] et, input logic [3:0] eo, input logic em,
                         input int restart_at, input string tag);
        int s;
        s = settle_of(d);
        box_r[d] = box;
        exp_w[d] = expv;
        @(negedge clk);
        start_w[d] = 1'b1;
        @(negedge clk);
        start_w[d] = 1'b0;
        chk({tag, "_clr_table"}, 32'(tbl_w[d]), 32'd0);
        chk({tag, "_clr_ones"}, 32'(ones_w[d]), 32'd0);
        for (int n = 0; n < 8 * s; n++) begin
            if (n != 0) @(negedge clk);
            start_w[d] = (n == restart_at);
            chk({tag, "_busy"}, 32'(busy_w[d]), 32'd1);
            chk({tag, "_done_early"}, 32'(done_w[d]), 32'd0);
            chk({tag, "_jvf"}, 32'({j_w[d], v_w[d], f_w[d]}), 32'(n / s));
        end
        @(negedge clk);
        start_w[d] = 1'b0;
        chk({tag, "_done"}, 32'(done_w[d]), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy_w[d]), 32'd0);
        chk({tag, "_table"}, 32'(tbl_w[d]), 32'(et));
        chk({tag, "_ones"}, 32'(ones_w[d]), 32'(eo));
        chk({tag, "_match"}, 32'(match_w[d]), 32'(em));
        chk({tag, "_jvf_end"}, 32'({j_w[d], v_w[d], f_w[d]}), 32'd0);
    endtask

    initial begin
        logic [7:0] rb, re;
        int         rd;

        // Standard box l = f & (~v | j) -> minterms 1,5,7 -> 8'hA2
        vecs[0] = '{d: 0, box: 8'hA2, expv: 8'hA2, et: 8'hA2, eo: 4'd3, em: 1'b1};
        vecs[1] = '{d: 1, box: 8'hFF, expv: 8'hA2, et: 8'hFF, eo: 4'd8, em: 1'b0};
        vecs[2] = '{d: 0, box: 8'h80, expv: 8'h80, et: 8'h80, eo: 4'd1, em: 1'b1};
        vecs[3] = '{d: 0, box: 8'h00, expv: 8'h00, et: 8'h00, eo: 4'd0, em: 1'b1};
        vecs[4] = '{d: 1, box: 8'h01, expv: 8'h80, et: 8'h01, eo: 4'd1, em: 1'b0};
        vecs[5] = '{d: 0, box: 8'h5A, expv: 8'h5A, et: 8'h5A, eo: 4'd4, em: 1'b1};

        rst_w   = 2'b11;
        start_w = 2'b00;
        exp_w   = '0;
        box_r   = '0;
        repeat (2) @(negedge clk);
        chk_idle(0, "reset1");
        chk_idle(1, "reset3");
        rst_w = 2'b00;

        // Table of full sweeps
        for (int i = 0; i < 6; i++) begin
            sweep(vecs[i].d, vecs[i].box, vecs[i].expv, vecs[i].et, vecs[i].eo,
                  vecs[i].em, -1, "vec");
        end

        // Changing expected after DONE entry does not move match
        exp_w[0] = 8'h00;
        @(negedge clk);
        chk("match_hold", 32'(match_w[0]), 32'd1);
        chk("done_hold", 32'(done_w[0]), 32'd1);

        // Start during RUN is ignored; then restart straight from DONE
        sweep(0, 8'hA2, 8'hA2, 8'hA2, 4'd3, 1'b1, 3, "run_start");
        sweep(0, 8'h3C, 8'h3C, 8'h3C, 4'd4, 1'b1, -1, "restart");

        // Reset mid-sweep discards the partial table
        box_r[0] = 8'hFF;
        exp_w[0] = 8'hFF;
        @(negedge clk);
        start_w[0] = 1'b1;
        @(negedge clk);
        start_w[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 32'(busy_w[0]), 32'd1);
        rst_w[0] = 1'b1;
        @(negedge clk);
        rst_w[0] = 1'b0;
        chk_idle(0, "mid_rst");
        sweep(0, 8'hFF, 8'hFF, 8'hFF, 4'd8, 1'b1, -1, "post_rst");

        // Reset and start together: reset wins
        @(negedge clk);
        rst_w[0]   = 1'b1;
        start_w[0] = 1'b1;
        @(negedge clk);
        rst_w[0]   = 1'b0;
        start_w[0] = 1'b0;
        chk_idle(0, "rst_start");
        @(negedge clk);
        chk("rst_start_stay", 32'(busy_w[0]), 32'd0);

        // Random boxes against the truth-table model
        for (int i = 0; i < 24; i++) begin
            rd = int'($urandom_range(0, 1));
            rb = 8'($urandom);
            re = ($urandom_range(0, 1) == 0) ? rb : 8'($urandom);
            sweep(rd, rb, re, rb, 4'($countones(rb)), (rb == re), -1, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
